// File: rtl/aes_pkg.sv
// Shared AES definitions: controller FSM encoding, AES-128 round constants and
// the GF(2^8) doubling helper also used by the mixing_column matrix multiply.
package aes_pkg;

   localparam int         AES_NR    = 10;
   localparam logic [7:0] RCON_INIT = 8'h01;
   localparam logic [7:0] RCON_POLY = 8'h1B;

   typedef logic [1:0] fsm_state_t;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ROUND = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   // Multiply by x in GF(2^8) modulo the AES polynomial.
   function automatic logic [7:0] xtime8(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Rcon generator for the AES-128 key schedule: 8-bit register that is loaded
// with the first constant at block start and doubled in GF(2^8) each round.
module aes_rcon_gen
   import aes_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       step,
   output logic [7:0] rcon
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rcon <= RCON_INIT;
      else if (load)
         rcon <= RCON_INIT;
      else if (step)
         rcon <= xtime8(rcon);
   end

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer driving an external round datapath.
// Optional abort input enabled by defining AES_ROUND_CTRL_ABORT_EN.
module aes_round_ctrl
   import aes_pkg::*;
#(
   parameter int NR   = AES_NR,
   parameter int RC_W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_pt,
   input  logic [127:0] in_key,
`ifdef AES_ROUND_CTRL_ABORT_EN
   input  logic         abort,
`endif
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_ct,
   output logic         busy,
   output logic [127:0] rnd_state_o,
   output logic [127:0] rnd_key_o,
   output logic [7:0]   rnd_rcon_o,
   output logic         rnd_last_o,
   input  logic [127:0] rnd_state_i,
   input  logic [127:0] rnd_key_i
);

   localparam logic [RC_W-1:0] LAST_RND = RC_W'(NR);

   fsm_state_t        fsm_q;
   logic [RC_W-1:0]   round_q;
   logic [127:0]      state_q;
   logic [127:0]      key_q;
   logic [127:0]      ct_q;
   logic              accept;
   logic              in_round;
   logic              is_last;
   logic              abort_req;

   assign accept   = in_valid && (fsm_q == IDLE);
   assign in_round = (fsm_q == ROUND);
   assign is_last  = in_round && (round_q == LAST_RND);

`ifdef AES_ROUND_CTRL_ABORT_EN
   assign abort_req = abort && (fsm_q != IDLE);
`else
   assign abort_req = 1'b0;
`endif

   // Ciphertext is kept in its own register so out_ct keeps showing the last
   // result while the next block is being processed in state_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q   <= IDLE;
         round_q <= '0;
         state_q <= '0;
         key_q   <= '0;
         ct_q    <= '0;
      end else if (abort_req) begin
         fsm_q   <= IDLE;
         round_q <= '0;
         state_q <= '0;
         key_q   <= '0;
      end else begin
         case (fsm_q)
            IDLE: begin
               if (in_valid) begin
                  state_q <= in_pt ^ in_key;
                  key_q   <= in_key;
                  round_q <= RC_W'(1);
                  fsm_q   <= ROUND;
               end
            end
            ROUND: begin
               state_q <= rnd_state_i;
               key_q   <= rnd_key_i;
               if (is_last) begin
                  ct_q  <= rnd_state_i;
                  fsm_q <= DONE;
               end else begin
                  round_q <= round_q + RC_W'(1);
               end
            end
            DONE: begin
               if (out_ready)
                  fsm_q <= IDLE;
            end
            default: fsm_q <= IDLE;
         endcase
      end
   end

   aes_rcon_gen u_rcon (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (accept),
      .step  (in_round && !abort_req),
      .rcon  (rnd_rcon_o)
   );

   assign in_ready    = (fsm_q == IDLE);
   assign out_valid   = (fsm_q == DONE);
   assign busy        = (fsm_q != IDLE);
   assign out_ct      = ct_q;
   assign rnd_state_o = state_q;
   assign rnd_key_o   = key_q;
   assign rnd_last_o  = is_last;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl with a behavioural AES-128 round
// datapath attached and a whole-block reference model for random vectors.
module tb_aes_round_ctrl;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_pt;
   logic [127:0] in_key;
`ifdef AES_ROUND_CTRL_ABORT_EN
   logic         abort;
`endif
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_ct;
   logic         busy;
   logic [127:0] rnd_state_o;
   logic [127:0] rnd_key_o;
   logic [7:0]   rnd_rcon_o;
   logic         rnd_last_o;
   logic [127:0] rnd_state_i;
   logic [127:0] rnd_key_i;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   aes_round_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_pt       (in_pt),
      .in_key      (in_key),
`ifdef AES_ROUND_CTRL_ABORT_EN
      .abort       (abort),
`endif
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_ct      (out_ct),
      .busy        (busy),
      .rnd_state_o (rnd_state_o),
      .rnd_key_o   (rnd_key_o),
      .rnd_rcon_o  (rnd_rcon_o),
      .rnd_last_o  (rnd_last_o),
      .rnd_state_i (rnd_state_i),
      .rnd_key_i   (rnd_key_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S-box from first principles: multiplicative inverse (x^254) then affine map.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] v;
      v = 8'h01;
      for (int i = 7; i >= 0; i--) begin
         v = gmul(v, v);
         if (i != 0) v = gmul(v, x);
      end
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 4; c++)
         for (int rw = 0; rw < 4; rw++)
            r[127-8*(rw+4*c) -: 8] = sbox(s[127-8*(rw+4*((c+rw)%4)) -: 8]);
      return r;
   endfunction

   function automatic logic [127:0] mix(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0]   a0, a1, a2, a3;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         r[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
         r[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
         r[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
         r[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
      return r;
   endfunction

   function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3, t;
      w3 = k[31:0];
      t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
      w0 = k[127:96] ^ t;
      w1 = k[95:64] ^ w0;
      w2 = k[63:32] ^ w1;
      w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   function automatic logic [127:0] aes_encrypt(input logic [127:0] key, input logic [127:0] pt);
      logic [127:0] s, k;
      logic [7:0]   rc;
      s  = pt ^ key;
      k  = key;
      rc = 8'h01;
      for (int r = 1; r <= 10; r++) begin
         k = next_key(k, rc);
         s = sub_shift(s);
         if (r < 10) s = mix(s);
         s  = s ^ k;
         rc = gmul(rc, 8'h02);
      end
      return s;
   endfunction

   always_comb begin
      rnd_key_i   = next_key(rnd_key_o, rnd_rcon_o);
      rnd_state_i = (rnd_last_o ? sub_shift(rnd_state_o) : mix(sub_shift(rnd_state_o))) ^ rnd_key_i;
   end

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [127:0] key, input logic [127:0] pt);
      int waited;
      waited = 0;
      while (!in_ready && waited < 40) begin
         @(posedge clk); #1;
         waited++;
      end
      checkOutput("accept_ready", 128'(in_ready), 128'(1));
      in_key   = key;
      in_pt    = pt;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // One full block: optional per-round checks, hold in DONE, optional dropped pulse.
   task automatic runBlock(input logic [127:0] key, input logic [127:0] pt,
                           input logic [127:0] exp_ct, input int ready_delay,
                           input bit check_rounds, input bit pulse_in);
      int         edges;
      logic [7:0] exp_rcon;
      out_ready = (ready_delay == 0);
      applyStimulus(key, pt);
      edges    = 0;
      exp_rcon = 8'h01;
      while (!out_valid && edges < 40) begin
         if (check_rounds) begin
            checkOutput($sformatf("rcon_r%0d", edges + 1), 128'(rnd_rcon_o), 128'(exp_rcon));
            checkOutput($sformatf("last_r%0d", edges + 1), 128'(rnd_last_o), 128'(edges == 9));
            checkOutput($sformatf("busy_r%0d", edges + 1), 128'(busy), 128'(1));
            checkOutput($sformatf("in_ready_r%0d", edges + 1), 128'(in_ready), 128'(0));
         end
         exp_rcon = gmul(exp_rcon, 8'h02);
         @(posedge clk); #1;
         edges++;
      end
      checkOutput("latency", 128'(edges), 128'(10));
      checkOutput("ct", out_ct, exp_ct);
      checkOutput("done_busy", 128'(busy), 128'(1));
      for (int i = 0; i < ready_delay; i++) begin
         if (pulse_in) begin
            in_valid = (i == 2);
            in_pt    = ~pt;
         end
         @(posedge clk); #1;
         checkOutput("hold_valid", 128'(out_valid), 128'(1));
         checkOutput("hold_ct", out_ct, exp_ct);
         checkOutput("hold_in_ready", 128'(in_ready), 128'(0));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput("release_busy_valid_ready", 128'({busy, out_valid, in_ready}), 128'(3'b001));
   endtask

   typedef struct packed {
      logic [127:0] key;
      logic [127:0] pt;
      logic [127:0] ct;
   } vec_t;

   vec_t vecs [3];

   initial begin
      int           t1, t2, edges;
      bit           seen_idle;
      logic [127:0] rk, rp;

      vecs[0] = {128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
      vecs[1] = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                 128'h3925841d02dc09fbdc118597196a0b32};
      vecs[2] = {128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_pt     = '0;
      in_key    = '0;
      out_ready = 1'b1;
`ifdef AES_ROUND_CTRL_ABORT_EN
      abort     = 1'b0;
`endif
      #12;
      checkOutput("rst_in_ready", 128'(in_ready), 128'(1));
      checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
      checkOutput("rst_busy", 128'(busy), 128'(0));
      checkOutput("rst_out_ct", out_ct, 128'h0);
      checkOutput("rst_state", rnd_state_o, 128'h0);
      checkOutput("rst_key", rnd_key_o, 128'h0);
      checkOutput("rst_rcon", 128'(rnd_rcon_o), 128'(8'h01));
      checkOutput("rst_last", 128'(rnd_last_o), 128'(0));
      #11 rst_n = 1'b1;
      @(posedge clk); #1;

      // FIPS-197 C.1 with per-round Rcon / last checks
      runBlock(vecs[0].key, vecs[0].pt, vecs[0].ct, 0, 1'b1, 1'b0);

      // Known-answer table
      for (int i = 0; i < 3; i++)
         runBlock(vecs[i].key, vecs[i].pt, vecs[i].ct, i, 1'b0, 1'b0);

      // Backpressure for 5 cycles with a stray in_valid pulse that must be dropped
      runBlock(vecs[0].key, vecs[0].pt, vecs[0].ct, 5, 1'b0, 1'b1);
      @(posedge clk); #1;
      checkOutput("pulse_dropped", 128'(busy), 128'(0));

      // Back-to-back with in_valid held
      out_ready = 1'b1;
      in_key    = vecs[1].key;
      in_pt     = vecs[1].pt;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      t1     = cyc;
      in_key = vecs[0].key;
      in_pt  = vecs[0].pt;
      edges  = 0;
      while (!out_valid && edges < 40) begin @(posedge clk); #1; edges++; end
      checkOutput("b2b_ct1", out_ct, vecs[1].ct);
      edges     = 0;
      seen_idle = 1'b0;
      while (!(seen_idle && busy) && edges < 40) begin
         @(posedge clk); #1;
         edges++;
         if (!busy) seen_idle = 1'b1;
      end
      t2       = cyc;
      in_valid = 1'b0;
      checkOutput("b2b_spacing", 128'(t2 - t1), 128'(12));
      edges = 0;
      while (!out_valid && edges < 40) begin @(posedge clk); #1; edges++; end
      checkOutput("b2b_latency2", 128'(edges), 128'(10));
      checkOutput("b2b_ct2", out_ct, vecs[0].ct);
      @(posedge clk); #1;

      // Asynchronous reset during round 5
      applyStimulus(vecs[0].key, vecs[0].pt);
      repeat (4) begin @(posedge clk); #1; end
      checkOutput("pre_rst_rcon", 128'(rnd_rcon_o), 128'(8'h10));
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midrst_flags", 128'({busy, out_valid, in_ready}), 128'(3'b001));
      checkOutput("midrst_state", rnd_state_o, 128'h0);
      checkOutput("midrst_out_ct", out_ct, 128'h0);
      checkOutput("midrst_rcon", 128'(rnd_rcon_o), 128'(8'h01));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      runBlock(vecs[0].key, vecs[0].pt, vecs[0].ct, 0, 1'b0, 1'b0);

`ifdef AES_ROUND_CTRL_ABORT_EN
      // Abort during round 3, then verify no output appears and the next block is clean
      applyStimulus(vecs[0].key, vecs[0].pt);
      repeat (2) begin @(posedge clk); #1; end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      checkOutput("abort_flags", 128'({busy, out_valid, in_ready}), 128'(3'b001));
      checkOutput("abort_state", rnd_state_o, 128'h0);
      checkOutput("abort_key", rnd_key_o, 128'h0);
      edges = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (out_valid) edges++;
      end
      checkOutput("abort_no_valid", 128'(edges), 128'(0));
      runBlock(vecs[1].key, vecs[1].pt, vecs[1].ct, 0, 1'b0, 1'b0);
`endif

      // Random blocks against the whole-block reference model
      for (int i = 0; i < 8; i++) begin
         rk = {$urandom, $urandom, $urandom, $urandom};
         rp = {$urandom, $urandom, $urandom, $urandom};
         runBlock(rk, rp, aes_encrypt(rk, rp), int'($urandom_range(0, 3)), 1'b0, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
